score_bcd_converter: RTL and testbench

- Sequential binary-to-BCD converter between score_counter and display_4digit.
- Uses shift-add-3 (double-dabble), one bit per clock.
- Watches the binary score and reconverts whenever it changes.
- Holds the last converted BCD word stable, so the 7-segment display never shows partial results; saturates to all nines on overflow.

---
 rtl/game_pkg.sv | 21 ++
 rtl/bcd_digit_adjust.sv | 11 +
 rtl/score_bcd_converter.sv | 93 +++++++++
 tb/tb_score_bcd_converter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants, state encoding and helpers for the score display path.
package game_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam logic [BCD_DIGIT_W-1:0] BCD_NINE = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   // Elaboration-time 10**n, used to size the saturation limit.
   function automatic int unsigned pow10(input int unsigned n);
      int unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit cell: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
   import game_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] adjusted
);

   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/score_bcd_converter.sv
// Sequential binary-to-BCD converter (one bit per clock) that holds the last
// result stable for the display and saturates to all nines on overflow.
module score_bcd_converter
   import game_pkg::*;
#(
   parameter int BIN_WIDTH  = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [BIN_WIDTH-1:0]              value,
   output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] bcd,
   output logic                              valid,
   output logic                              busy,
   output logic                              overflow
);

   localparam int                ACC_W      = BCD_DIGIT_W * NUM_DIGITS;
   localparam int unsigned       MAX_VALUE  = pow10(NUM_DIGITS) - 1;
   localparam int                CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;
   localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(BIN_WIDTH - 1);
   localparam logic [ACC_W-1:0]  ALL_NINES  = {NUM_DIGITS{BCD_NINE}};

   conv_state_e          state;
   logic [CNT_W-1:0]     cnt;
   logic [BIN_WIDTH-1:0] bin_sr;
   logic [BIN_WIDTH-1:0] captured;
   logic [BIN_WIDTH-1:0] last_value;
   logic [ACC_W-1:0]     acc;
   logic [ACC_W-1:0]     acc_adj;
   logic                 force_conv;
   logic                 ovf_pending;

   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .adjusted (acc_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         bin_sr      <= '0;
         captured    <= '0;
         last_value  <= '0;
         acc         <= '0;
         force_conv  <= 1'b1;
         ovf_pending <= 1'b0;
         bcd         <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // force_conv makes the first cycle after reset convert even if
               // value happens to equal the cleared last_value.
               if ((value != last_value) || force_conv) begin
                  bin_sr      <= value;
                  captured    <= value;
                  acc         <= '0;
                  ovf_pending <= (32'(value) > MAX_VALUE);
                  busy        <= 1'b1;
                  cnt         <= '0;
                  force_conv  <= 1'b0;
                  state       <= SHIFT;
               end else begin
                  busy <= 1'b0;
               end
            end
            SHIFT: begin
               // Top bits falling off acc only happen when saturation hides them.
               acc    <= {acc_adj[ACC_W-2:0], bin_sr[BIN_WIDTH-1]};
               bin_sr <= {bin_sr[BIN_WIDTH-2:0], 1'b0};
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_SHIFT) state <= DONE;
            end
            DONE: begin
               bcd        <= ovf_pending ? ALL_NINES : acc;
               overflow   <= ovf_pending;
               valid      <= 1'b1;
               last_value <= captured;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Self-checking bench for score_bcd_converter: transaction-level reference
// model compared every cycle, plus directed literal checks.
module tb_score_bcd_converter;

   localparam int BIN_WIDTH = 14;
   localparam int LATENCY   = BIN_WIDTH + 1;

   logic        clk;
   logic        rst;
   logic [13:0] value;
   logic [15:0] bcd;
   logic        valid;
   logic        busy;
   logic        overflow;

   int n_pass;
   int n_total;

   score_bcd_converter #(.BIN_WIDTH(14), .NUM_DIGITS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .value    (value),
      .bcd      (bcd),
      .valid    (valid),
      .busy     (busy),
      .overflow (overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // reference: decimal digits by plain arithmetic, saturating above 9999
   function automatic logic [15:0] to_bcd(input int v);
      int r;
      if (v > 9999) return 16'h9999;
      r = ((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + (v % 10);
      return 16'(r);
   endfunction

   // transaction-level model: a conversion occupies LATENCY cycles after capture
   logic [15:0] m_bcd;
   logic        m_valid, m_busy, m_ovf, m_force, started;
   int          m_last, m_cap, cyc_left;

   initial begin
      started  = 1'b0;
      m_last   = 0;
      cyc_left = 0;
      n_pass   = 0;
      n_total  = 0;
   end

   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         m_bcd = 16'h0; m_valid = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
         m_force = 1'b1; cyc_left = 0;
      end else if (cyc_left == 0) begin
         if ((int'(value) != m_last) || m_force) begin
            m_cap = int'(value); m_force = 1'b0; m_busy = 1'b1; cyc_left = LATENCY;
         end else begin
            m_busy = 1'b0;
         end
      end else begin
         cyc_left--;
         if (cyc_left == 0) begin
            m_bcd = to_bcd(m_cap); m_ovf = (m_cap > 9999); m_valid = 1'b1;
            m_last = m_cap; m_busy = 1'b0;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // per-cycle scoreboard against the model
   always @(negedge clk) begin
      if (started) begin
         check("cyc_bcd",      32'(bcd),      32'(m_bcd));
         check("cyc_valid",    32'(valid),    32'(m_valid));
         check("cyc_busy",     32'(busy),     32'(m_busy));
         check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   // driver tasks
   task automatic drive(input logic [13:0] v);
      @(posedge clk);
      #1 value = v;
   endtask

   task automatic wait_capture(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (busy) n_pass++;
      else $display("FAIL %s: busy never rose within 40 cycles (got 0 expected 1)", name);
   endtask

   // called at the negedge after the capture edge
   task automatic check_result(input string name, input logic [15:0] exp_bcd, input logic exp_ovf);
      repeat (LATENCY - 1) @(posedge clk);
      @(negedge clk);
      check({name, "_busy_pre"}, 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check({name, "_bcd"},      32'(bcd),      32'(exp_bcd));
      check({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
      check({name, "_valid"},    32'(valid),    32'd1);
      check({name, "_busy"},     32'(busy),     32'd0);
   endtask

   task automatic convert(input string name, input logic [13:0] v, input logic [15:0] exp_bcd, input logic exp_ovf);
      drive(v);
      wait_capture(name);
      check_result(name, exp_bcd, exp_ovf);
   endtask

   initial begin
      logic [13:0] v;
      rst = 1'b1;
      value = 14'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_bcd",   32'(bcd),   32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("post_reset_busy", 32'(busy), 32'd1);
      check_result("reset_conv", 16'h0000, 1'b0);

      convert("basic_1234", 14'd1234, 16'h1234, 1'b0);
      repeat (50) begin
         @(negedge clk);
         check("stable_busy", 32'(busy), 32'd0);
         check("stable_bcd",  32'(bcd),  32'h1234);
      end

      convert("b_9999",  14'd9999,  16'h9999, 1'b0);
      convert("b_10000", 14'd10000, 16'h9999, 1'b1);
      convert("b_16383", 14'd16383, 16'h9999, 1'b1);
      convert("b_42",    14'd42,    16'h0042, 1'b0);

      // value change while converting
      drive(14'd100);
      wait_capture("mid_100");
      repeat (5) @(posedge clk);
      #1 value = 14'd257;
      repeat (LATENCY - 6) @(posedge clk);
      @(negedge clk);
      check("mid_busy_pre", 32'(busy), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("mid_first_bcd", 32'(bcd), 32'h0100);
      @(posedge clk);
      @(negedge clk);
      check("mid_rebusy", 32'(busy), 32'd1);
      check_result("mid_257", 16'h0257, 1'b0);

      // reset in the middle of a conversion
      drive(14'd5555);
      wait_capture("rst_5555");
      repeat (6) @(posedge clk);
      #1 begin rst = 1'b1; value = 14'd0; end
      @(posedge clk);
      @(negedge clk);
      check("rst_mid_bcd",   32'(bcd),   32'd0);
      check("rst_mid_valid", 32'(valid), 32'd0);
      check("rst_mid_busy",  32'(busy),  32'd0);
      rst = 1'b0;
      wait_capture("rst_recover");
      check_result("rst_recover", 16'h0000, 1'b0);

      // sweep across the whole range with a stride, then random values
      for (int i = 1; i < 16384; i += 13) begin
         v = 14'(i);
         convert("sweep", v, to_bcd(i), (i > 9999));
      end
      for (int i = 9990; i <= 10010; i++) begin
         v = 14'(i);
         convert("edge", v, to_bcd(i), (i > 9999));
      end
      for (int i = 0; i < 600; i++) begin
         v = 14'($urandom_range(0, 16383));
         if (v == value) v = v ^ 14'd1;
         convert("rand", v, to_bcd(int'(v)), (int'(v) > 9999));
      end

      // free-running changes at random intervals, checked by the per-cycle model
      for (int i = 0; i < 300; i++) begin
         drive(14'($urandom_range(0, 16383)));
         repeat ($urandom_range(0, 20)) @(posedge clk);
      end
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
